// File: rtl/vc_resp_crossbar3.sv
// vc_resp_crossbar3: registered, arbitrated 3x3 response crossbar.
// Routes responses from three targets back to three initiators. Each output
// has a round-robin arbiter and a one-entry buffer that can drain and refill
// in the same cycle.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   in{0,1,2}_val/rdy          input handshake (rdy is combinational)
//   in{0,1,2}_msg/dest/domain  payload, destination (3 = illegal), domain tag
//   out{0,1,2}_val/rdy         output handshake (val is registered)
//   out{0,1,2}_msg/domain      buffered payload and its domain tag
//   drop_err                   sticky flag: an illegal-destination response was discarded
module vc_resp_crossbar3 #(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic [1:0]         in0_dest,
    input  logic               in0_domain,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    input  logic [1:0]         in1_dest,
    input  logic               in1_domain,
    input  logic               in2_val,
    output logic               in2_rdy,
    input  logic [p_nbits-1:0] in2_msg,
    input  logic [1:0]         in2_dest,
    input  logic               in2_domain,
    output logic               out0_val,
    input  logic               out0_rdy,
    output logic [p_nbits-1:0] out0_msg,
    output logic               out0_domain,
    output logic               out1_val,
    input  logic               out1_rdy,
    output logic [p_nbits-1:0] out1_msg,
    output logic               out1_domain,
    output logic               out2_val,
    input  logic               out2_rdy,
    output logic [p_nbits-1:0] out2_msg,
    output logic               out2_domain,
    output logic               drop_err
);

    localparam int unsigned NPORTS = 3;
    localparam int unsigned PTR_W  = 2;

    // Port bundling into arrays so the arbiters can be written as loops.
    logic [NPORTS-1:0]  in_val_a;
    logic [NPORTS-1:0]  in_dom_a;
    logic [NPORTS-1:0]  out_rdy_a;
    logic [1:0]         in_dest_a [NPORTS];
    logic [p_nbits-1:0] in_msg_a  [NPORTS];
    logic [NPORTS-1:0]  in_rdy_c;

    assign in_val_a  = {in2_val, in1_val, in0_val};
    assign in_dom_a  = {in2_domain, in1_domain, in0_domain};
    assign out_rdy_a = {out2_rdy, out1_rdy, out0_rdy};
    assign in_dest_a[0] = in0_dest;
    assign in_dest_a[1] = in1_dest;
    assign in_dest_a[2] = in2_dest;
    assign in_msg_a[0]  = in0_msg;
    assign in_msg_a[1]  = in1_msg;
    assign in_msg_a[2]  = in2_msg;

    // Buffer, arbiter pointer and error-flag state.
    logic [NPORTS-1:0]  out_val_q, out_val_d;
    logic [NPORTS-1:0]  out_dom_q, out_dom_d;
    logic [p_nbits-1:0] out_msg_q [NPORTS];
    logic [p_nbits-1:0] out_msg_d [NPORTS];
    logic [PTR_W-1:0]   ptr_q     [NPORTS];
    logic [PTR_W-1:0]   ptr_d     [NPORTS];
    logic               drop_err_q, drop_err_d;

    // (base + off) mod 3 for operands in 0..2.
    function automatic logic [PTR_W-1:0] rr_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W-1:0] off);
        logic [2:0] sum;
        sum = 3'(base) + 3'(off);
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return PTR_W'(sum);
    endfunction

    // Arbitration, input ready, buffer load/drain and drop detection.
    always_comb begin : arb_comb
        logic             found;
        logic [PTR_W-1:0] idx;
        in_rdy_c   = '0;
        out_val_d  = out_val_q;
        out_dom_d  = out_dom_q;
        drop_err_d = drop_err_q;
        found      = 1'b0;
        idx        = '0;
        for (int j = 0; j < NPORTS; j++) begin
            out_msg_d[j] = out_msg_q[j];
            ptr_d[j]     = ptr_q[j];
        end

        for (int j = 0; j < NPORTS; j++) begin
            found = 1'b0;
            // No grants while reset is asserted: nothing may be accepted.
            if (reset && (!out_val_q[j] || out_rdy_a[j])) begin
                for (int k = 0; k < NPORTS; k++) begin
                    idx = rr_add(ptr_q[j], PTR_W'(k));
                    if (!found && in_val_a[idx] && (in_dest_a[idx] == 2'(j))) begin
                        found         = 1'b1;
                        in_rdy_c[idx] = 1'b1;
                        out_msg_d[j]  = in_msg_a[idx];
                        out_dom_d[j]  = in_dom_a[idx];
                        ptr_d[j]      = rr_add(idx, 2'd1);
                    end
                end
            end
            if (found) begin
                out_val_d[j] = 1'b1;
            end else if (out_val_q[j] && out_rdy_a[j]) begin
                out_val_d[j] = 1'b0;
            end
        end

        // Illegal destination: accept and discard, flag the error.
        for (int i = 0; i < NPORTS; i++) begin
            if (reset && in_val_a[i] && (in_dest_a[i] == 2'd3)) begin
                in_rdy_c[i] = 1'b1;
                drop_err_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_val_q  <= '0;
            out_dom_q  <= '0;
            drop_err_q <= 1'b0;
            for (int j = 0; j < NPORTS; j++) begin
                out_msg_q[j] <= '0;
                ptr_q[j]     <= '0;
            end
        end else begin
            out_val_q  <= out_val_d;
            out_dom_q  <= out_dom_d;
            drop_err_q <= drop_err_d;
            for (int j = 0; j < NPORTS; j++) begin
                out_msg_q[j] <= out_msg_d[j];
                ptr_q[j]     <= ptr_d[j];
            end
        end
    end

    assign in0_rdy     = in_rdy_c[0];
    assign in1_rdy     = in_rdy_c[1];
    assign in2_rdy     = in_rdy_c[2];
    assign out0_val    = out_val_q[0];
    assign out1_val    = out_val_q[1];
    assign out2_val    = out_val_q[2];
    assign out0_msg    = out_msg_q[0];
    assign out1_msg    = out_msg_q[1];
    assign out2_msg    = out_msg_q[2];
    assign out0_domain = out_dom_q[0];
    assign out1_domain = out_dom_q[1];
    assign out2_domain = out_dom_q[2];
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_vc_resp_crossbar3.sv
// Directed testbench for vc_resp_crossbar3: reset, single transfer,
// round-robin fairness, backpressure, parallel routing and illegal drops.
module tb_vc_resp_crossbar3;

    logic        clk;
    logic        reset;
    logic        in0_val, in1_val, in2_val;
    logic        in0_rdy, in1_rdy, in2_rdy;
    logic [31:0] in0_msg, in1_msg, in2_msg;
    logic [1:0]  in0_dest, in1_dest, in2_dest;
    logic        in0_domain, in1_domain, in2_domain;
    logic        out0_val, out1_val, out2_val;
    logic        out0_rdy, out1_rdy, out2_rdy;
    logic [31:0] out0_msg, out1_msg, out2_msg;
    logic        out0_domain, out1_domain, out2_domain;
    logic        drop_err;

    int errors = 0;
    int checks = 0;

    vc_resp_crossbar3 #(.p_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg), .in0_dest(in0_dest), .in0_domain(in0_domain),
        .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg), .in1_dest(in1_dest), .in1_domain(in1_domain),
        .in2_val(in2_val), .in2_rdy(in2_rdy), .in2_msg(in2_msg), .in2_dest(in2_dest), .in2_domain(in2_domain),
        .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg), .out0_domain(out0_domain),
        .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg), .out1_domain(out1_domain),
        .out2_val(out2_val), .out2_rdy(out2_rdy), .out2_msg(out2_msg), .out2_domain(out2_domain),
        .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_val = 1'b0; in1_val = 1'b0; in2_val = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in0_msg = 32'h1111_0000; in0_dest = 2'd0; in0_domain = 1'b0; in0_val = 1'b1;
        in1_msg = '0; in1_dest = 2'd0; in1_domain = 1'b0; in1_val = 1'b0;
        in2_msg = '0; in2_dest = 2'd0; in2_domain = 1'b0; in2_val = 1'b0;
        out0_rdy = 1'b0; out1_rdy = 1'b0; out2_rdy = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (out0_val !== 1'b0) begin errors++; $display("FAIL reset_out0_val: got %b want 0", out0_val); end
        checks++; if (in0_rdy !== 1'b0) begin errors++; $display("FAIL reset_in0_rdy: got %b want 0", in0_rdy); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
        checks++; if ({out2_val, out1_val} !== 2'b00) begin errors++; $display("FAIL reset_out12_val: got %b want 00", {out2_val, out1_val}); end
        checks++; if (out1_msg !== 32'h0 || out1_domain !== 1'b0) begin errors++; $display("FAIL reset_out1_msg: got %h/%b want 0/0", out1_msg, out1_domain); end
        reset = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_single();
        in1_msg = 32'hA5A5_0001; in1_dest = 2'd2; in1_domain = 1'b1; in1_val = 1'b1;
        out2_rdy = 1'b1;
        #2;
        checks++; if (in1_rdy !== 1'b1) begin errors++; $display("FAIL single_in1_rdy: got %b want 1", in1_rdy); end
        checks++; if (out2_val !== 1'b0) begin errors++; $display("FAIL single_pre_val: got %b want 0", out2_val); end
        next_cycle();
        in1_val = 1'b0;
        checks++; if (out2_val !== 1'b1) begin errors++; $display("FAIL single_out2_val: got %b want 1", out2_val); end
        checks++; if (out2_msg !== 32'hA5A5_0001) begin errors++; $display("FAIL single_out2_msg: got %h want a5a50001", out2_msg); end
        checks++; if (out2_domain !== 1'b1) begin errors++; $display("FAIL single_out2_domain: got %b want 1", out2_domain); end
        next_cycle();
        checks++; if (out2_val !== 1'b0 || out2_msg !== 32'hA5A5_0001) begin errors++; $display("FAIL single_drain: got val=%b msg=%h want 0/a5a50001", out2_val, out2_msg); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_rdy;
        logic [31:0] exp_msg;
        logic        exp_dom;
        in0_msg = 32'h0000_0100; in0_dest = 2'd0; in0_domain = 1'b0; in0_val = 1'b1;
        in1_msg = 32'h0000_0101; in1_dest = 2'd0; in1_domain = 1'b1; in1_val = 1'b1;
        in2_msg = 32'h0000_0102; in2_dest = 2'd0; in2_domain = 1'b0; in2_val = 1'b1;
        out0_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = 3'b001 << (c % 3);
            exp_msg = 32'h0000_0100 + 32'(c % 3);
            exp_dom = ((c % 3) == 1);
            #2;
            checks++; if ({in2_rdy, in1_rdy, in0_rdy} !== exp_rdy) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", c, {in2_rdy, in1_rdy, in0_rdy}, exp_rdy); end
            next_cycle();
            checks++; if (out0_val !== 1'b1 || out0_msg !== exp_msg || out0_domain !== exp_dom) begin errors++; $display("FAIL rr_out0_%0d: got val=%b msg=%h dom=%b want 1/%h/%b", c, out0_val, out0_msg, out0_domain, exp_msg, exp_dom); end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_backpressure();
        out1_rdy = 1'b0;
        in0_msg = 32'h0000_00B0; in0_dest = 2'd1; in0_domain = 1'b0; in0_val = 1'b1;
        next_cycle();
        in0_val = 1'b0;
        in2_msg = 32'h0000_00B2; in2_dest = 2'd1; in2_domain = 1'b1; in2_val = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (in2_rdy !== 1'b0) begin errors++; $display("FAIL bp_in2_rdy_%0d: got %b want 0", c, in2_rdy); end
            checks++; if (out1_val !== 1'b1 || out1_msg !== 32'h0000_00B0) begin errors++; $display("FAIL bp_hold_%0d: got val=%b msg=%h want 1/000000b0", c, out1_val, out1_msg); end
            next_cycle();
        end
        out1_rdy = 1'b1;
        #2;
        checks++; if (in2_rdy !== 1'b1) begin errors++; $display("FAIL bp_refill_rdy: got %b want 1", in2_rdy); end
        next_cycle();
        in2_val = 1'b0;
        checks++; if (out1_val !== 1'b1 || out1_msg !== 32'h0000_00B2 || out1_domain !== 1'b1) begin errors++; $display("FAIL bp_refill: got val=%b msg=%h dom=%b want 1/000000b2/1", out1_val, out1_msg, out1_domain); end
        next_cycle();
    endtask

    task automatic test_parallel();
        out0_rdy = 1'b1; out1_rdy = 1'b1; out2_rdy = 1'b1;
        in0_msg = 32'h0000_00C0; in0_dest = 2'd1; in0_domain = 1'b1; in0_val = 1'b1;
        in1_msg = 32'h0000_00C1; in1_dest = 2'd2; in1_domain = 1'b0; in1_val = 1'b1;
        in2_msg = 32'h0000_00C2; in2_dest = 2'd0; in2_domain = 1'b1; in2_val = 1'b1;
        #2;
        checks++; if ({in2_rdy, in1_rdy, in0_rdy} !== 3'b111) begin errors++; $display("FAIL par_rdy: got %b want 111", {in2_rdy, in1_rdy, in0_rdy}); end
        next_cycle();
        idle_inputs();
        checks++; if (out0_val !== 1'b1 || out0_msg !== 32'h0000_00C2 || out0_domain !== 1'b1) begin errors++; $display("FAIL par_out0: got %b/%h/%b want 1/000000c2/1", out0_val, out0_msg, out0_domain); end
        checks++; if (out1_val !== 1'b1 || out1_msg !== 32'h0000_00C0 || out1_domain !== 1'b1) begin errors++; $display("FAIL par_out1: got %b/%h/%b want 1/000000c0/1", out1_val, out1_msg, out1_domain); end
        checks++; if (out2_val !== 1'b1 || out2_msg !== 32'h0000_00C1 || out2_domain !== 1'b0) begin errors++; $display("FAIL par_out2: got %b/%h/%b want 1/000000c1/0", out2_val, out2_msg, out2_domain); end
        next_cycle();
    endtask

    task automatic test_drop();
        in2_msg = 32'h0000_DEAD; in2_dest = 2'd3; in2_domain = 1'b0; in2_val = 1'b1;
        #2;
        checks++; if (in2_rdy !== 1'b1) begin errors++; $display("FAIL drop_in2_rdy: got %b want 1", in2_rdy); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_err_early: got %b want 0", drop_err); end
        next_cycle();
        in2_val = 1'b0;
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_set: got %b want 1", drop_err); end
        checks++; if ({out2_val, out1_val, out0_val} !== 3'b000) begin errors++; $display("FAIL drop_no_out: got %b want 000", {out2_val, out1_val, out0_val}); end
        next_cycle();
        next_cycle();
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky: got %b want 1", drop_err); end
        reset = 1'b0;
        next_cycle();
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_err_reset: got %b want 0", drop_err); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_parallel();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
